imuldiv_int_muldiv_param: RTL and testbench

Parametrised iterative integer multiply/divide unit that supersedes the fixed 32-bit split mul/div pair in the `imuldiv` library. A single shared datapath serves all functions: full-width signed and unsigned multiply, signed and unsigned divide, and signed and unsigned remainder. Operand width and bits retired per cycle are configurable. It sits behind the pipeline's val/rdy muldiv request/response interface, and its results are packed the same way as the existing unit's.

---
 rtl/imuldiv_int_muldiv_param_pkg.sv | 30 +++
 rtl/imuldiv_muldiv_step.sv | 35 +++
 rtl/imuldiv_int_muldiv_param.sv | 151 +++++++++++++++
 tb/tb_imuldiv_int_muldiv_param.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_int_muldiv_param_pkg.sv
// Shared definitions for the parametrised multiply/divide unit:
// function codes, FSM state encoding and small decode helpers.
package imuldiv_int_muldiv_param_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;
    localparam logic [2:0] FN_MULU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fnIsMul(input logic [2:0] fn);
        return (fn == FN_MUL) || (fn == FN_MULU);
    endfunction

    function automatic logic fnIsSigned(input logic [2:0] fn);
        return (fn == FN_MUL) || (fn == FN_DIV) || (fn == FN_REM);
    endfunction

    function automatic logic fnIsDiv(input logic [2:0] fn);
        return (fn == FN_DIV) || (fn == FN_DIVU) || (fn == FN_REM) || (fn == FN_REMU);
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_step.sv
// One radix-2 step of the shared datapath: shift-add multiply or
// restoring divide, selected by i_divMode. Purely combinational.
module imuldiv_muldiv_step
    import imuldiv_int_muldiv_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_divMode,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_remShift;
    logic           w_ge;

    // The partial remainder only needs W+1 bits transiently after the
    // shift; once D is subtracted it always fits back into W bits.
    always_comb begin
        w_sum      = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
        w_remShift = {i_hi, i_lo[WIDTH-1]};
        w_ge       = (w_remShift >= {1'b0, i_m});
        if (i_divMode) begin
            o_hi = w_ge ? WIDTH'(w_remShift - {1'b0, i_m}) : w_remShift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/imuldiv_int_muldiv_param.sv
// Iterative signed/unsigned multiply, divide and remainder unit with a
// val/rdy request/response interface; BITS_PER_CYCLE steps per clock.
module imuldiv_int_muldiv_param
    import imuldiv_int_muldiv_param_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         muldivreq_msg_fn,
    input  logic [WIDTH-1:0]   muldivreq_msg_a,
    input  logic [WIDTH-1:0]   muldivreq_msg_b,
    input  logic               muldivreq_val,
    output logic               muldivreq_rdy,
    output logic [2*WIDTH-1:0] muldivresp_msg_result,
    output logic               muldivresp_val,
    input  logic               muldivresp_rdy
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t r_state, w_nextState;

    logic [2:0]         r_fn;
    logic               r_sa, r_sb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_result;

    logic               w_reqHs, w_respHs;
    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_absA, w_absB;
    logic [WIDTH-1:0]   w_hiEnd, w_loEnd;
    logic [WIDTH-1:0]   w_quot, w_rem;
    logic [2*WIDTH-1:0] w_prodMag, w_prod, w_final;

    assign w_reqHs  = muldivreq_val && muldivreq_rdy;
    assign w_respHs = muldivresp_val && muldivresp_rdy;

    assign w_sa   = fnIsSigned(muldivreq_msg_fn) && muldivreq_msg_a[WIDTH-1];
    assign w_sb   = fnIsSigned(muldivreq_msg_fn) && muldivreq_msg_b[WIDTH-1];
    assign w_absA = w_sa ? -muldivreq_msg_a : muldivreq_msg_a;
    assign w_absB = w_sb ? -muldivreq_msg_b : muldivreq_msg_b;

    // Chain of single-bit steps; each stage feeds the next within one clock.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_stage
        logic [WIDTH-1:0] w_hiIn, w_loIn, w_hiOut, w_loOut;
        if (g == 0) begin : g_first
            assign w_hiIn = r_hi;
            assign w_loIn = r_lo;
        end else begin : g_next
            assign w_hiIn = g_stage[g-1].w_hiOut;
            assign w_loIn = g_stage[g-1].w_loOut;
        end
        imuldiv_muldiv_step #(.WIDTH(WIDTH)) u_step (
            .i_divMode (!fnIsMul(r_fn)),
            .i_hi      (w_hiIn),
            .i_lo      (w_loIn),
            .i_m       (r_m),
            .o_hi      (w_hiOut),
            .o_lo      (w_loOut)
        );
    end

    assign w_hiEnd = g_stage[BITS_PER_CYCLE-1].w_hiOut;
    assign w_loEnd = g_stage[BITS_PER_CYCLE-1].w_loOut;

    // Sign fix and divide-by-zero override, applied to the final step's output.
    always_comb begin
        w_prodMag = {w_hiEnd, w_loEnd};
        w_prod    = (r_sa ^ r_sb) ? -w_prodMag : w_prodMag;
        w_quot    = (r_sa ^ r_sb) ? -w_loEnd : w_loEnd;
        w_rem     = r_sa ? -w_hiEnd : w_hiEnd;
        if (r_m == '0) begin
            w_quot = '1;
            w_rem  = r_a;
        end
        if (fnIsMul(r_fn)) begin
            w_final = w_prod;
        end else if (fnIsDiv(r_fn)) begin
            w_final = {w_rem, w_quot};
        end else begin
            w_final = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; DONE may go straight back to CALC for back-to-back ops.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_reqHs) w_nextState = ST_CALC;
            ST_CALC: if (r_count == '0) w_nextState = ST_DONE;
            ST_DONE: if (w_respHs) w_nextState = w_reqHs ? ST_CALC : ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        muldivreq_rdy  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && muldivresp_rdy);
        muldivresp_val = (r_state == ST_DONE);
    end

    // Operand capture, iteration and result latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fn     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a      <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_reqHs) begin
            r_fn    <= muldivreq_msg_fn;
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_a     <= muldivreq_msg_a;
            r_m     <= fnIsMul(muldivreq_msg_fn) ? w_absA : w_absB;
            r_lo    <= fnIsMul(muldivreq_msg_fn) ? w_absB : w_absA;
            r_hi    <= '0;
            r_count <= CW'(STEPS - 1);
        end else if (r_state == ST_CALC) begin
            r_hi <= w_hiEnd;
            r_lo <= w_loEnd;
            if (r_count == '0) begin
                r_result <= w_final;
            end else begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign muldivresp_msg_result = r_result;

endmodule

// File: tb/tb_imuldiv_int_muldiv_param.sv
// Directed and randomised checks for the 32-bit/1-bit-per-cycle and
// 16-bit/4-bit-per-cycle configurations of the multiply/divide unit.
module tb_imuldiv_int_muldiv_param;
    import imuldiv_int_muldiv_param_pkg::*;

    localparam int NOPS = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [2:0]  fn32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        reqVal32 = 1'b0, reqRdy32, respVal32, respRdy32 = 1'b1;
    logic [63:0] result32;

    logic [2:0]  fn16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        reqVal16 = 1'b0, reqRdy16, respVal16, respRdy16 = 1'b1;
    logic [31:0] result16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imuldiv_int_muldiv_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(fn32), .muldivreq_msg_a(a32), .muldivreq_msg_b(b32),
        .muldivreq_val(reqVal32), .muldivreq_rdy(reqRdy32),
        .muldivresp_msg_result(result32), .muldivresp_val(respVal32), .muldivresp_rdy(respRdy32)
    );

    imuldiv_int_muldiv_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(fn16), .muldivreq_msg_a(a16), .muldivreq_msg_b(b16),
        .muldivreq_val(reqVal16), .muldivreq_rdy(reqRdy16),
        .muldivresp_msg_result(result16), .muldivresp_val(respVal16), .muldivresp_rdy(respRdy16)
    );

    // Reference model for the 16-bit unit built on native SV arithmetic.
    function automatic logic [31:0] golden16(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, q, r;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        case (fn)
            FN_MUL:  begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            FN_MULU: begin p = longint'(a) * longint'(b); return p[31:0]; end
            FN_DIV, FN_REM: begin
                if (b == 16'h0) return {a, 16'hFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[15:0], q[15:0]};
            end
            FN_DIVU, FN_REMU: begin
                if (b == 16'h0) return {a, 16'hFFFF};
                return {a % b, a / b};
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Issue one op on the 32-bit unit and report its result and latency.
    task automatic runOp32(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat);
        int guard = 0;
        @(negedge clk);
        fn32 = fn; a32 = a; b32 = b; reqVal32 = 1'b1;
        while (!reqRdy32 && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        reqVal32 = 1'b0;
        fn32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
        lat = 0;
        while (!respVal32 && lat < 200) begin @(posedge clk); #1; lat++; end
        res = result32;
        if (!respVal32) begin
            errors++; checks++;
            $display("[TB] FAIL op32_timeout: got no response, required one within 200 cycles");
        end
        if (respRdy32) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (respVal32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_val: got %b want 0", respVal32); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (reqRdy32 !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy: got %b want 1", reqRdy32); end
        checks++;
        if (result32 !== 64'h0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result32); end
        checks++;
        if (reqRdy16 !== 1'b1 || respVal16 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_16: got rdy=%b val=%b want rdy=1 val=0", reqRdy16, respVal16);
        end
    endtask

    task automatic test_multiply();
        logic [63:0] res;
        int lat;
        runOp32(FN_MUL, -32'sd3, 32'd7, res, lat);
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("[TB] FAIL mul_neg: got %h want ffffffffffffffeb", res); end
        checks++;
        if (lat != 32) begin errors++; $display("[TB] FAIL mul_latency: got %0d want 32", lat); end
        runOp32(FN_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        checks++;
        if (res !== 64'hFFFFFFFE_00000001) begin errors++; $display("[TB] FAIL mulu_max: got %h want fffffffe00000001", res); end
        runOp32(FN_MUL, 32'h80000000, 32'h80000000, res, lat);
        checks++;
        if (res !== 64'h40000000_00000000) begin errors++; $display("[TB] FAIL mul_min_sq: got %h want 4000000000000000", res); end
    endtask

    task automatic test_divide();
        logic [63:0] res;
        int lat;
        runOp32(FN_DIV, -32'sd7, 32'd2, res, lat);
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("[TB] FAIL div_neg: got %h want fffffffffffffffd", res); end
        runOp32(FN_REM, -32'sd7, 32'd2, res, lat);
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("[TB] FAIL rem_neg: got %h want fffffffffffffffd", res); end
        runOp32(FN_REMU, 32'd7, 32'd2, res, lat);
        checks++;
        if (res !== 64'h00000001_00000003) begin errors++; $display("[TB] FAIL remu: got %h want 0000000100000003", res); end
        runOp32(FN_DIV, 32'd100, -32'sd7, res, lat);
        checks++;
        if (res !== 64'h00000002_FFFFFFF2) begin errors++; $display("[TB] FAIL div_negdiv: got %h want 00000002fffffff2", res); end
    endtask

    task automatic test_div_boundary();
        logic [63:0] res;
        int lat;
        runOp32(FN_DIV, 32'h80000000, 32'hFFFFFFFF, res, lat);
        checks++;
        if (res !== 64'h00000000_80000000) begin errors++; $display("[TB] FAIL div_overflow: got %h want 0000000080000000", res); end
        runOp32(FN_DIV, -32'sd5, 32'd0, res, lat);
        checks++;
        if (res !== 64'hFFFFFFFB_FFFFFFFF) begin errors++; $display("[TB] FAIL div_zero_signed: got %h want fffffffbffffffff", res); end
        runOp32(FN_DIVU, 32'd9, 32'd0, res, lat);
        checks++;
        if (res !== 64'h00000009_FFFFFFFF) begin errors++; $display("[TB] FAIL divu_zero: got %h want 00000009ffffffff", res); end
        runOp32(3'd6, 32'd123, 32'd45, res, lat);
        checks++;
        if (res !== 64'h0 || lat != 32) begin errors++; $display("[TB] FAIL fn_unused: got %h lat %0d want 0 lat 32", res, lat); end
    endtask

    task automatic test_reset_mid_calc();
        logic [63:0] res;
        int lat;
        bit sawVal = 1'b0;
        @(negedge clk);
        fn32 = FN_MUL; a32 = 32'd5; b32 = 32'd6; reqVal32 = 1'b1;
        @(posedge clk); #1;
        reqVal32 = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (respVal32 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_val: got %b want 0", respVal32); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (reqRdy32 !== 1'b1) begin errors++; $display("[TB] FAIL midreset_rdy: got %b want 1", reqRdy32); end
        repeat (40) begin @(negedge clk); if (respVal32) sawVal = 1'b1; end
        checks++;
        if (sawVal) begin errors++; $display("[TB] FAIL midreset_noresp: got a response, want none"); end
        runOp32(FN_MULU, 32'd3, 32'd4, res, lat);
        checks++;
        if (res !== 64'd12) begin errors++; $display("[TB] FAIL midreset_next: got %h want c", res); end
    endtask

    task automatic test_back_pressure();
        int lat = 0;
        respRdy32 = 1'b0;
        @(negedge clk);
        fn32 = FN_DIVU; a32 = 32'd100; b32 = 32'd7; reqVal32 = 1'b1;
        @(posedge clk); #1;
        fn32 = FN_MULU; a32 = 32'd6; b32 = 32'd7;
        while (!respVal32 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 32) begin errors++; $display("[TB] FAIL bp_latency: got %0d want 32", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (result32 !== 64'h00000002_0000000E || reqRdy32 !== 1'b0 || respVal32 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold: got res=%h rdy=%b val=%b want 000000020000000e rdy=0 val=1",
                         result32, reqRdy32, respVal32);
            end
        end
        respRdy32 = 1'b1;
        #1;
        checks++;
        if (reqRdy32 !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_rdy: got %b want 1", reqRdy32); end
        @(posedge clk); #1;
        reqVal32 = 1'b0;
        checks++;
        if (respVal32 !== 1'b0) begin errors++; $display("[TB] FAIL bp_b2b_val: got %b want 0", respVal32); end
        lat = 0;
        while (!respVal32 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 32 || result32 !== 64'd42) begin
            errors++; $display("[TB] FAIL bp_next: got res=%h lat=%0d want 2a lat 32", result32, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random16();
        logic [31:0] expQ[$];
        int accQ[$];
        int cycle = 0, respCount = 0, lat;
        bit prevVal = 1'b0;
        fork
            begin
                for (int i = 0; i < NOPS; i++) begin
                    int guard = 0;
                    bit accepted = 1'b0;
                    @(negedge clk);
                    reqVal16 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    fn16 = 3'($urandom_range(0, 7)); a16 = pick16(); b16 = pick16(); reqVal16 = 1'b1;
                    while (!accepted && guard < 200) begin
                        @(posedge clk);
                        if (reqVal16 && reqRdy16) accepted = 1'b1;
                        guard++;
                    end
                    if (!accepted) begin
                        errors++; checks++;
                        $display("[TB] FAIL rand_accept: got no accept for op %0d within 200 cycles", i);
                        break;
                    end
                end
                @(negedge clk);
                reqVal16 = 1'b0;
            end
            begin
                while (respCount < NOPS && cycle < 30000) begin
                    @(posedge clk);
                    cycle++;
                    if (reqVal16 && reqRdy16) begin
                        expQ.push_back(golden16(fn16, a16, b16));
                        accQ.push_back(cycle);
                    end
                    // Valid rises just after the accept edge + 4, so the first
                    // posedge that samples it high is 5 edges after the accept.
                    if (respVal16 && !prevVal) begin
                        checks++;
                        if (accQ.size() == 0) begin
                            errors++; $display("[TB] FAIL rand_spurious: got a response with no request outstanding");
                        end else begin
                            lat = cycle - accQ.pop_front();
                            if (lat != 5) begin errors++; $display("[TB] FAIL rand_latency: got %0d want 5", lat); end
                        end
                    end
                    if (respVal16 && respRdy16) begin
                        checks++;
                        if (expQ.size() == 0) begin
                            errors++; $display("[TB] FAIL rand_dup: got extra response %h", result16);
                        end else if (result16 !== expQ[0]) begin
                            errors++; $display("[TB] FAIL rand_result: got %h want %h", result16, expQ[0]);
                            void'(expQ.pop_front());
                        end else begin
                            void'(expQ.pop_front());
                        end
                        respCount++;
                    end
                    prevVal = respVal16;
                    @(negedge clk);
                    respRdy16 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        respRdy16 = 1'b1;
        checks++;
        if (respCount != NOPS || expQ.size() != 0) begin
            errors++; $display("[TB] FAIL rand_count: got %0d responses want %0d", respCount, NOPS);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_boundary();
        test_reset_mid_calc();
        test_back_pressure();
        test_random16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
